rotate_in_buffer: RTL and testbench
===================================

# rotate_in_buffer

Input pixel buffer between the AHB read DMA and `core_pixel`. It holds one 192-byte transfer block: 64 RGB pixels, 3 bytes each, at byte addresses 0x00–0xBF. The DMA side writes four byte lanes per beat. The core side reads one pixel (R, G, B bytes at independent addresses) per cycle with 1-cycle latency. A fill/drain state machine tracks occupancy, raises FULL when a block is complete, and releases the buffer after 64 pixel reads.

## Interface
- P_DEPTH, 192, storage size in bytes; valid byte addresses 0..P_DEPTH-1
- P_PIXELS, 64, pixel reads per drain
- I_IB_HCLK  in  1  clock
- I_IB_HRESET_N  in  1  reset; asynchronous, active-low
- I_IB_CLEAR  in  1  synchronous block abort/restart
- I_IB_WR_EN  in  1  write strobe
- I_IB_WR_ADDR0..3  in  8 each  byte address of lane 0..3
- I_IB_WR_DATA  in  32  lane n data = bits [8n+7:8n]
- I_IB_RD_EN  in  1  pixel read strobe
- I_IB_RD_ADDRR / G / B  in  8 each  byte addresses of R/G/B
- O_IB_RD_R / G / B  out  8 each  read data
- O_IB_RD_VALID  out  1  read data valid
- O_IB_WR_COUNT  out  8  in-range bytes written this block (0..192)
- O_IB_FULL  out  1  block complete, readable
- O_IB_EMPTY  out  1  nothing written this block
- O_IB_ERR  out  1  sticky protocol/range error

## Operation
- States:
  - S_FILL (reset state)
  - S_FULL
  - S_DRAIN
- S_FILL, on WR_EN:
  - Each lane with address < 192 writes its byte.
  - Lanes with address ≥ 192 are dropped and set ERR.
  - WR_COUNT += number of in-range lanes (0–4), saturating at 192.
- S_FILL → S_FULL when the updated count equals 192.
- S_FULL → S_DRAIN on the first RD_EN. That read is serviced and counted.
- S_DRAIN: a 6-bit read counter increments on each serviced RD_EN.
- S_DRAIN → S_FILL on the RD_EN that takes the counter from 63 to 64 (64th read). On that transition: WR_COUNT := 0, read counter := 0. Storage contents are retained.
- Reads in S_FULL or S_DRAIN: each lane whose address is < 192 returns the stored byte. An address ≥ 192 returns 0x00 on that lane and sets ERR.
- Reads in S_FILL: ignored. RD_VALID stays 0, data outputs hold, ERR set.
- Writes in S_FULL or S_DRAIN: ignored, ERR set. No storage or count change.
- Duplicate addresses within one write beat: the highest-numbered lane wins (lane 3 > 2 > 1 > 0). Count still adds every in-range lane.
- CLEAR has priority over WR_EN and RD_EN in the same cycle:
  - state := S_FILL
  - WR_COUNT := 0, read counter := 0
  - RD_VALID := 0, ERR := 0
  - storage untouched
- ERR is cleared only by reset or CLEAR.
- EMPTY = (state == S_FILL) && (WR_COUNT == 0).
- FULL = (state == S_FULL) || (state == S_DRAIN).
- WR_COUNT is 8 bits unsigned; the maximum value 192 fits without wrap.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state S_FILL
  - O_IB_RD_R/G/B = 0x00, O_IB_RD_VALID = 0
  - O_IB_WR_COUNT = 0, O_IB_FULL = 0, O_IB_EMPTY = 1, O_IB_ERR = 0
  - storage contents are undefined after reset
- Reset mid-block behaves as reset; any partial block is discarded.
- All outputs are registered.
- Write latency:
  - a byte written at edge N is readable by RD_EN sampled at edge N+1
  - WR_COUNT, FULL and EMPTY reflect the write after edge N
- Read latency 1: RD_EN sampled at edge N gives data and RD_VALID=1 after edge N. RD_VALID=1 for exactly one cycle per serviced read.
- Back-to-back reads are allowed every cycle. 64 consecutive RD_EN cycles drain the block in 64 cycles.
- The first write of the next block is accepted in the cycle after the 64th read (state is then S_FILL).
- FULL deasserts, and EMPTY asserts, after the edge that samples the 64th RD_EN.
- No stall/ready output. Upstream must honour FULL, and downstream must honour FULL before reading.

## Test plan
- Fill and drain:
  - 48 beats WR_EN, addresses 4k..4k+3, data = address bytes; WR_COUNT reaches 192 and FULL=1 after beat 48, EMPTY=0.
  - Then 64 reads at addresses 3k/3k+1/3k+2; each returns bytes 3k..3k+2, one cycle after RD_EN.
  - FULL=0 and EMPTY=1 after the 64th read; ERR=0 throughout.
- Out-of-range write: beat with ADDR0..3 = 0xBE, 0xBF, 0xC0, 0xC1 → WR_COUNT += 2, ERR=1. Reading 0xC0 after FULL returns 0x00.
- Protocol errors:
  - RD_EN in S_FILL → RD_VALID stays 0, ERR=1.
  - After CLEAR (ERR=0), fill to FULL, then WR_EN → storage and count unchanged, ERR=1.
- Duplicate lanes: all four lanes at address 0x10, data 0xDDCCBBAA → stored byte 0xDD, WR_COUNT += 4.
- CLEAR priority: CLEAR together with WR_EN and RD_EN while in S_DRAIN after 10 reads → next cycle state S_FILL, WR_COUNT=0, EMPTY=1, RD_VALID=0, ERR=0.
- Asynchronous reset:
  - assert I_IB_HRESET_N low mid-cycle during S_DRAIN → outputs at reset values immediately, without waiting for a clock edge;
  - after release, a new 48-beat fill reaches FULL normally.

Source files
------------

// File: rtl/rotate_in_buffer.sv
// rotate_in_buffer
// ----------------
// Input pixel buffer between the AHB read DMA and core_pixel. It holds one
// transfer block of P_DEPTH bytes (64 RGB pixels, 3 bytes each). The DMA
// writes up to four byte lanes per beat. The core reads one pixel per cycle
// (R, G and B at independent byte addresses) with one cycle of latency. A
// fill/full/drain state machine tracks occupancy.
//
// Handshake: there is no ready/stall. A write beat is accepted on any cycle
// where I_IB_WR_EN is high and the buffer is filling. A pixel read is
// serviced on any cycle where I_IB_RD_EN is high and the buffer is full or
// draining. Its data appears with O_IB_RD_VALID=1 for exactly one cycle
// after the sampling edge. Strobes outside those states are dropped and
// flagged in the sticky O_IB_ERR.
//
// Ports:
//   I_IB_HCLK, I_IB_HRESET_N      clock, async active-low reset
//   I_IB_CLEAR                    synchronous block abort (highest priority)
//   I_IB_WR_EN, I_IB_WR_ADDR0..3  write strobe and per-lane byte addresses
//   I_IB_WR_DATA                  lane n = bits [8n+7:8n]
//   I_IB_RD_EN, I_IB_RD_ADDRR/G/B pixel read strobe and byte addresses
//   O_IB_RD_R/G/B, O_IB_RD_VALID  registered read data and valid
//   O_IB_WR_COUNT                 in-range bytes written this block
//   O_IB_FULL, O_IB_EMPTY         occupancy flags
//   O_IB_ERR                      sticky protocol/range error
//   O_IB_DBG_STATE                FSM state (0 fill, 1 full, 2 drain)
module rotate_in_buffer #(
  parameter int P_DEPTH  = 192,
  parameter int P_PIXELS = 64
) (
  input  logic        I_IB_HCLK,
  input  logic        I_IB_HRESET_N,
  input  logic        I_IB_CLEAR,
  input  logic        I_IB_WR_EN,
  input  logic [7:0]  I_IB_WR_ADDR0,
  input  logic [7:0]  I_IB_WR_ADDR1,
  input  logic [7:0]  I_IB_WR_ADDR2,
  input  logic [7:0]  I_IB_WR_ADDR3,
  input  logic [31:0] I_IB_WR_DATA,
  input  logic        I_IB_RD_EN,
  input  logic [7:0]  I_IB_RD_ADDRR,
  input  logic [7:0]  I_IB_RD_ADDRG,
  input  logic [7:0]  I_IB_RD_ADDRB,
  output logic [7:0]  O_IB_RD_R,
  output logic [7:0]  O_IB_RD_G,
  output logic [7:0]  O_IB_RD_B,
  output logic        O_IB_RD_VALID,
  output logic [7:0]  O_IB_WR_COUNT,
  output logic        O_IB_FULL,
  output logic        O_IB_EMPTY,
  output logic        O_IB_ERR,
  output logic [1:0]  O_IB_DBG_STATE
);

  localparam int              RC_W    = $clog2(P_PIXELS);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(P_PIXELS - 1);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
  localparam logic [8:0]      DEPTH9  = 9'(P_DEPTH);
  localparam logic [7:0]      DEPTH8  = 8'(P_DEPTH);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [7:0]        rd_r_q, rd_r_d;
  logic [7:0]        rd_g_q, rd_g_d;
  logic [7:0]        rd_b_q, rd_b_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic [7:0]        mem_q [P_DEPTH];
  logic              mem_we;

  logic [7:0]        wa [4];
  logic [7:0]        wd [4];
  logic [3:0]        lane_ok;
  logic [2:0]        n_ok;
  logic [8:0]        sum9;
  logic              ok_r, ok_g, ok_b;

  assign wa[0] = I_IB_WR_ADDR0;
  assign wa[1] = I_IB_WR_ADDR1;
  assign wa[2] = I_IB_WR_ADDR2;
  assign wa[3] = I_IB_WR_ADDR3;
  assign wd[0] = I_IB_WR_DATA[7:0];
  assign wd[1] = I_IB_WR_DATA[15:8];
  assign wd[2] = I_IB_WR_DATA[23:16];
  assign wd[3] = I_IB_WR_DATA[31:24];

  assign ok_r = (I_IB_RD_ADDRR < DEPTH8);
  assign ok_g = (I_IB_RD_ADDRG < DEPTH8);
  assign ok_b = (I_IB_RD_ADDRB < DEPTH8);

  always_comb begin
    lane_ok = '0;
    n_ok    = '0;
    for (int l = 0; l < 4; l++) begin
      lane_ok[l] = (wa[l] < DEPTH8);
      n_ok       = n_ok + {2'b00, lane_ok[l]};
    end
  end

  // 9-bit sum so count + 4 never wraps before the saturation compare.
  assign sum9 = {1'b0, cnt_q} + {6'd0, n_ok};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    rd_r_d  = rd_r_q;
    rd_g_d  = rd_g_q;
    rd_b_d  = rd_b_q;
    rv_d    = 1'b0;
    err_d   = err_q;
    mem_we  = 1'b0;

    if (I_IB_CLEAR) begin
      state_d = S_FILL;
      cnt_d   = '0;
      rc_d    = '0;
      err_d   = 1'b0;
    end else begin
      if (I_IB_WR_EN) begin
        if (state_q == S_FILL) begin
          mem_we = 1'b1;
          if (!(&lane_ok)) err_d = 1'b1;
          if (sum9 >= DEPTH9) begin
            cnt_d   = DEPTH8;
            state_d = S_FULL;
          end else begin
            cnt_d = sum9[7:0];
          end
        end else begin
          err_d = 1'b1;
        end
      end

      if (I_IB_RD_EN) begin
        if (state_q == S_FILL) begin
          err_d = 1'b1;
        end else begin
          rv_d   = 1'b1;
          rd_r_d = ok_r ? mem_q[I_IB_RD_ADDRR] : 8'h00;
          rd_g_d = ok_g ? mem_q[I_IB_RD_ADDRG] : 8'h00;
          rd_b_d = ok_b ? mem_q[I_IB_RD_ADDRB] : 8'h00;
          if (!(ok_r && ok_g && ok_b)) err_d = 1'b1;
          // The read that leaves FULL is the first of the block's reads.
          if (state_q == S_FULL) begin
            state_d = S_DRAIN;
            rc_d    = rc_q + RC_ONE;
          end else if (rc_q == RC_LAST) begin
            state_d = S_FILL;
            cnt_d   = '0;
            rc_d    = '0;
          end else begin
            rc_d = rc_q + RC_ONE;
          end
        end
      end
    end

    full_d  = (state_d != S_FILL);
    empty_d = (state_d == S_FILL) && (cnt_d == 8'd0);
  end

  always_ff @(posedge I_IB_HCLK or negedge I_IB_HRESET_N) begin
    if (!I_IB_HRESET_N) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      rc_q    <= '0;
      rd_r_q  <= '0;
      rd_g_q  <= '0;
      rd_b_q  <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      rd_r_q  <= rd_r_d;
      rd_g_q  <= rd_g_d;
      rd_b_q  <= rd_b_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage has no reset. Lanes are applied in ascending order so the
  // highest-numbered lane wins when a beat repeats an address.
  always_ff @(posedge I_IB_HCLK) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_ok[l]) mem_q[wa[l]] <= wd[l];
      end
    end
  end

  assign O_IB_RD_R      = rd_r_q;
  assign O_IB_RD_G      = rd_g_q;
  assign O_IB_RD_B      = rd_b_q;
  assign O_IB_RD_VALID  = rv_q;
  assign O_IB_WR_COUNT  = cnt_q;
  assign O_IB_FULL      = full_q;
  assign O_IB_EMPTY     = empty_q;
  assign O_IB_ERR       = err_q;
  assign O_IB_DBG_STATE = state_q;

endmodule

// File: tb/tb_rotate_in_buffer.sv
// Bench for rotate_in_buffer: reset checks, a table of directed vectors,
// hand-written fill/drain, duplicate-lane, protocol, CLEAR and async-reset
// sequences, then randomized traffic against a byte-array reference model.
module tb_rotate_in_buffer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        clear, wr_en, rd_en;
  logic [7:0]  wa [4];
  logic [31:0] wd;
  logic [7:0]  ra [3];
  logic [7:0]  o_r, o_g, o_b, o_cnt;
  logic        o_rv, o_full, o_empty, o_err;
  logic [1:0]  o_state;

  rotate_in_buffer dut (
    .I_IB_HCLK     (clk),
    .I_IB_HRESET_N (rst_n),
    .I_IB_CLEAR    (clear),
    .I_IB_WR_EN    (wr_en),
    .I_IB_WR_ADDR0 (wa[0]),
    .I_IB_WR_ADDR1 (wa[1]),
    .I_IB_WR_ADDR2 (wa[2]),
    .I_IB_WR_ADDR3 (wa[3]),
    .I_IB_WR_DATA  (wd),
    .I_IB_RD_EN    (rd_en),
    .I_IB_RD_ADDRR (ra[0]),
    .I_IB_RD_ADDRG (ra[1]),
    .I_IB_RD_ADDRB (ra[2]),
    .O_IB_RD_R     (o_r),
    .O_IB_RD_G     (o_g),
    .O_IB_RD_B     (o_b),
    .O_IB_RD_VALID (o_rv),
    .O_IB_WR_COUNT (o_cnt),
    .O_IB_FULL     (o_full),
    .O_IB_EMPTY    (o_empty),
    .O_IB_ERR      (o_err),
    .O_IB_DBG_STATE(o_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buffer as a byte array with a "has been written" flag per byte; phase is
  // 0 filling, 1 full, 2 draining; reads counts pixels taken this block.
  logic [7:0] m_mem [192];
  bit         m_known [192];
  int         m_phase, m_cnt, m_reads;
  bit         m_err, m_rv;
  int         m_out [3];
  bit         m_out_known [3];

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_reads = 0; m_err = 0; m_rv = 0;
    for (int i = 0; i < 192; i++) m_known[i] = 0;
    for (int c = 0; c < 3; c++) begin m_out[c] = 0; m_out_known[c] = 1; end
  endtask

  task automatic model_step();
    int phase0 = m_phase;
    int n = 0;
    int a;
    if (clear) begin
      m_phase = 0; m_cnt = 0; m_reads = 0; m_rv = 0; m_err = 0;
    end else begin
      m_rv = 0;
      if (wr_en) begin
        if (phase0 == 0) begin
          for (int l = 0; l < 4; l++) begin
            a = int'(wa[l]);
            if (a < 192) begin
              m_mem[a] = wd[8*l +: 8]; m_known[a] = 1; n++;
            end else m_err = 1;
          end
          m_cnt = (m_cnt + n > 192) ? 192 : m_cnt + n;
          if (m_cnt == 192) m_phase = 1;
        end else m_err = 1;
      end
      if (rd_en) begin
        if (phase0 == 0) m_err = 1;
        else begin
          m_rv = 1;
          for (int c = 0; c < 3; c++) begin
            a = int'(ra[c]);
            if (a < 192) begin
              m_out[c] = int'(m_mem[a]); m_out_known[c] = m_known[a];
            end else begin
              m_out[c] = 0; m_out_known[c] = 1; m_err = 1;
            end
          end
          m_reads++;
          m_phase = 2;
          if (m_reads == 64) begin m_phase = 0; m_cnt = 0; m_reads = 0; end
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("count", int'(o_cnt), m_cnt);
    chk("full", int'(o_full), int'(m_phase != 0));
    chk("empty", int'(o_empty), int'(m_phase == 0 && m_cnt == 0));
    chk("err", int'(o_err), int'(m_err));
    chk("rd_valid", int'(o_rv), int'(m_rv));
    if (m_out_known[0]) chk("rd_r", int'(o_r), m_out[0]);
    if (m_out_known[1]) chk("rd_g", int'(o_g), m_out[1]);
    if (m_out_known[2]) chk("rd_b", int'(o_b), m_out[2]);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are checked at
  // the same point, after the edge that consumed the previous inputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    clear = 0; wr_en = 0; rd_en = 0; wd = '0;
    for (int l = 0; l < 4; l++) wa[l] = '0;
    for (int c = 0; c < 3; c++) ra[c] = '0;
  endtask

  task automatic write_beat(input int k);
    idle();
    wr_en = 1;
    for (int l = 0; l < 4; l++) begin
      wa[l] = 8'(4*k + l);
      wd[8*l +: 8] = 8'(4*k + l);
    end
    cycle();
  endtask

  task automatic read_pixel(input int a_r, input int a_g, input int a_b);
    idle();
    rd_en = 1;
    ra[0] = 8'(a_r); ra[1] = 8'(a_g); ra[2] = 8'(a_b);
    cycle();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          clr, wr, rd;
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] data;
    logic [7:0]  raddr;
    int          e_cnt;
    bit          e_full, e_empty, e_err, e_rv;
  } vec_t;

  vec_t tbl [6];

  initial begin
    idle();
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    // Reset values appear without any clock edge.
    chk("reset_count", int'(o_cnt), 0);
    chk("reset_full", int'(o_full), 0);
    chk("reset_empty", int'(o_empty), 1);
    chk("reset_err", int'(o_err), 0);
    chk("reset_rv", int'(o_rv), 0);
    chk("reset_rgb", int'({o_r, o_g, o_b}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    tbl[0] = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0,        8'h00, 0, 0, 1, 0, 0};
    tbl[1] = '{0, 1, 0, 8'hBE, 8'hBF, 8'hC0, 8'hC1, 32'h44332211, 8'h00, 2, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0,        8'h05, 2, 0, 0, 1, 0};
    tbl[3] = '{0, 1, 0, 8'h10, 8'h10, 8'h10, 8'h10, 32'hDDCCBBAA, 8'h00, 6, 0, 0, 1, 0};
    tbl[4] = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0,        8'h00, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 1, 0, 8'h00, 8'h01, 8'h02, 8'h03, 32'h03020100, 8'h00, 4, 0, 0, 0, 0};

    for (int i = 0; i < 6; i++) begin
      idle();
      clear = tbl[i].clr; wr_en = tbl[i].wr; rd_en = tbl[i].rd;
      wa[0] = tbl[i].a0; wa[1] = tbl[i].a1; wa[2] = tbl[i].a2; wa[3] = tbl[i].a3;
      wd = tbl[i].data;
      ra[0] = tbl[i].raddr; ra[1] = tbl[i].raddr; ra[2] = tbl[i].raddr;
      cycle();
      chk($sformatf("tbl%0d_count", i), int'(o_cnt), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_full", i), int'(o_full), int'(tbl[i].e_full));
      chk($sformatf("tbl%0d_empty", i), int'(o_empty), int'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_err", i), int'(o_err), int'(tbl[i].e_err));
      chk($sformatf("tbl%0d_rv", i), int'(o_rv), int'(tbl[i].e_rv));
    end

    // ---- fill 48 beats, drain 64 pixels ----
    idle(); clear = 1; cycle();
    for (int k = 0; k < 48; k++) write_beat(k);
    chk("fill_count", int'(o_cnt), 192);
    chk("fill_full", int'(o_full), 1);
    chk("fill_empty", int'(o_empty), 0);
    for (int k = 0; k < 64; k++) begin
      read_pixel(3*k, 3*k + 1, 3*k + 2);
      chk("drain_rv", int'(o_rv), 1);
      chk("drain_rgb", int'({o_r, o_g, o_b}), int'({8'(3*k), 8'(3*k + 1), 8'(3*k + 2)}));
    end
    chk("drain_full", int'(o_full), 0);
    chk("drain_empty", int'(o_empty), 1);
    chk("drain_err", int'(o_err), 0);
    idle(); cycle();
    chk("rv_one_cycle", int'(o_rv), 0);

    // ---- duplicate lanes, then fill the rest of the block ----
    idle(); wr_en = 1;
    for (int l = 0; l < 4; l++) wa[l] = 8'h10;
    wd = 32'hDDCCBBAA;
    cycle();
    chk("dup_count", int'(o_cnt), 4);
    for (int k = 0; k < 48; k++) if (k != 4) write_beat(k);
    chk("refill_full", int'(o_full), 1);
    chk("refill_err", int'(o_err), 0);

    // ---- write while FULL is dropped ----
    idle(); wr_en = 1;
    for (int l = 0; l < 4; l++) wa[l] = 8'h10;
    wd = 32'h11111111;
    cycle();
    chk("full_wr_err", int'(o_err), 1);
    chk("full_wr_count", int'(o_cnt), 192);

    // ---- reads: duplicate-lane byte, out-of-range lane ----
    read_pixel(8'h10, 8'h11, 8'hC0);
    chk("dup_byte", int'(o_r), 8'hDD);
    chk("oor_read", int'(o_b), 0);
    for (int k = 1; k < 10; k++) read_pixel(3*k, 3*k + 1, 3*k + 2);

    // ---- CLEAR beats WR_EN and RD_EN in the same cycle ----
    idle(); clear = 1; wr_en = 1; rd_en = 1;
    wa[0] = 8'h20; ra[0] = 8'h21;
    cycle();
    chk("clr_count", int'(o_cnt), 0);
    chk("clr_empty", int'(o_empty), 1);
    chk("clr_full", int'(o_full), 0);
    chk("clr_rv", int'(o_rv), 0);
    chk("clr_err", int'(o_err), 0);
    chk("clr_state_fill", int'(o_state), 0);

    // ---- randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      idle();
      clear = ($urandom_range(0, 299) == 0);
      wr_en = (m_phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      rd_en = (m_phase != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      for (int l = 0; l < 4; l++)
        wa[l] = ($urandom_range(0, 99) < 97) ? 8'($urandom_range(0, 191)) : 8'($urandom_range(192, 255));
      wd = $urandom;
      for (int c = 0; c < 3; c++)
        ra[c] = ($urandom_range(0, 99) < 97) ? 8'($urandom_range(0, 191)) : 8'($urandom_range(192, 255));
      cycle();
    end

    // ---- asynchronous reset while draining ----
    idle(); clear = 1; cycle();
    for (int k = 0; k < 48; k++) write_beat(k);
    for (int k = 0; k < 5; k++) read_pixel(3*k, 3*k + 1, 3*k + 2);
    idle();
    chk("pre_rst_full", int'(o_full), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", int'(o_cnt), 0);
    chk("arst_full", int'(o_full), 0);
    chk("arst_empty", int'(o_empty), 1);
    chk("arst_err", int'(o_err), 0);
    chk("arst_rv", int'(o_rv), 0);
    chk("arst_rgb", int'({o_r, o_g, o_b}), 0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 48; k++) write_beat(k);
    chk("post_rst_full", int'(o_full), 1);
    chk("post_rst_count", int'(o_cnt), 192);
    read_pixel(0, 1, 2);
    chk("post_rst_rgb", int'({o_r, o_g, o_b}), int'(24'h000102));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
